// File: rtl/instruction_cache.sv
// instruction_cache: direct-mapped, read-only instruction cache between the CPU fetch stage
// and a 16-byte-block instruction memory. Hits return the word in the same cycle. A miss holds
// busywait, fetches the 128-bit block, refills the line and then replays the access.
// Ports: clock/reset (sync, active-high); address/readdata/busywait on the CPU side;
//        mem_read/mem_address/mem_readdata/mem_busywait on the memory side;
//        hit_count/miss_count statistics, built only when ICACHE_STATS_EN is defined (else 0).
// Latency: hit 0 stall cycles; miss = 1 miss cycle + memory cycles + 1 UPDATE cycle.
module instruction_cache #(
  parameter int ADDR_WIDTH = 10,
  parameter int INDEX_BITS = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] address,
  output logic [31:0]           readdata,
  output logic                  busywait,
  output logic                  mem_read,
  output logic [ADDR_WIDTH-5:0] mem_address,
  input  logic [127:0]          mem_readdata,
  input  logic                  mem_busywait,
  output logic [15:0]           hit_count,
  output logic [15:0]           miss_count
);

  localparam int LINES    = 1 << INDEX_BITS;
  localparam int BLK_BITS = ADDR_WIDTH - 4;
  localparam int TAG_BITS = ADDR_WIDTH - 4 - INDEX_BITS;

  typedef enum logic [1:0] {IDLE, MEM_READ, UPDATE} state_t;

  state_t                state_q;
  logic                  mem_read_q;
  logic [LINES-1:0]      valid_q;
  logic [TAG_BITS-1:0]   tag_q  [LINES];
  logic [127:0]          data_q [LINES];
  logic [BLK_BITS-1:0]   miss_blk_q;

  // Address fields of the current fetch.
  logic [INDEX_BITS-1:0] cur_idx;
  logic [TAG_BITS-1:0]   cur_tag;
  logic [1:0]            cur_word;
  logic                  hit;
  logic                  unused_addr_bits;

  // Fields of the latched miss block; the fill never looks at the live address.
  logic [INDEX_BITS-1:0] miss_idx;
  logic [TAG_BITS-1:0]   miss_tag;

  assign cur_idx          = address[INDEX_BITS+3:4];
  assign cur_tag          = address[ADDR_WIDTH-1:INDEX_BITS+4];
  assign cur_word         = address[3:2];
  assign unused_addr_bits = ^address[1:0];

  assign miss_idx = miss_blk_q[INDEX_BITS-1:0];
  assign miss_tag = miss_blk_q[BLK_BITS-1:INDEX_BITS];

  assign hit      = valid_q[cur_idx] && (tag_q[cur_idx] == cur_tag);
  assign readdata = data_q[cur_idx][{cur_word, 5'd0} +: 32];

  // Stall asserts in the miss cycle itself, is held through the whole fill, and is held low while reset is high.
  assign busywait = !reset && ((state_q != IDLE) || !hit);

  // Memory side depends only on registered state, never on the live address.
  assign mem_read    = mem_read_q;
  assign mem_address = miss_blk_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      mem_read_q <= 1'b0;
      valid_q    <= '0;
      miss_blk_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!hit) begin
            miss_blk_q <= address[ADDR_WIDTH-1:4];
            mem_read_q <= 1'b1;
            state_q    <= MEM_READ;
          end
        end
        MEM_READ: begin
          // The block is on mem_readdata once memory drops busywait.
          if (!mem_busywait) begin
            mem_read_q <= 1'b0;
            state_q    <= UPDATE;
          end
        end
        UPDATE: begin
          valid_q[miss_idx] <= 1'b1;
          state_q           <= IDLE;
        end
        default: begin
          mem_read_q <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  // Line storage is not reset; the valid bits alone decide whether a line is usable.
  always_ff @(posedge clock) begin
    if (!reset && (state_q == UPDATE)) begin
      data_q[miss_idx] <= mem_readdata;
      tag_q[miss_idx]  <= miss_tag;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [15:0] hit_cnt_q, hit_cnt_d;
  logic [15:0] miss_cnt_q, miss_cnt_d;

  // The replay cycle after UPDATE is an IDLE hit, so it is counted as a hit.
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if ((state_q == IDLE) && hit && (hit_cnt_q != 16'hFFFF)) begin
      hit_cnt_d = hit_cnt_q + 16'd1;
    end
    if ((state_q == IDLE) && !hit && (miss_cnt_q != 16'hFFFF)) begin
      miss_cnt_d = miss_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`else
  assign hit_count  = 16'd0;
  assign miss_count = 16'd0;
`endif

endmodule

// File: tb/tb_instruction_cache.sv
module tb_instruction_cache;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [9:0]   address = '0;
  logic [31:0]  readdata;
  logic         busywait;
  logic         mem_read;
  logic [5:0]   mem_address;
  logic [127:0] mem_readdata = '0;
  logic         mem_busywait = 1'b0;
  logic [15:0]  hit_count, miss_count;

  int total = 0;
  int bad   = 0;
  int lat   = 1;

  instruction_cache #(.ADDR_WIDTH(10), .INDEX_BITS(3)) dut (
    .clock(clock), .reset(reset), .address(address), .readdata(readdata),
    .busywait(busywait), .mem_read(mem_read), .mem_address(mem_address),
    .mem_readdata(mem_readdata), .mem_busywait(mem_busywait),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clock = ~clock;

  // Memory image: every word is a fixed function of block address and word number.
  function automatic logic [31:0] memword(input logic [5:0] b, input logic [1:0] w);
    return 32'(b) * 32'h0100_0193 + 32'(w) * 32'h9E37_79B9 + 32'h5A5A_0F0F;
  endfunction

  function automatic logic [127:0] memblock(input logic [5:0] b);
    return {memword(b, 2'd3), memword(b, 2'd2), memword(b, 2'd1), memword(b, 2'd0)};
  endfunction

  // Memory responder: raises busywait as soon as it sees a request, waits lat cycles,
  // then drops busywait with the block on mem_readdata (held until the next request).
  initial begin
    bit         pending = 0;
    int         cnt = 0;
    logic [5:0] req = '0;
    forever begin
      @(negedge clock);
      if (mem_read) begin
        if (!pending) begin
          pending = 1; cnt = lat; req = mem_address; mem_busywait = 1'b1;
        end else if (cnt > 0) begin
          cnt--;
        end else begin
          mem_readdata = memblock(req); mem_busywait = 1'b0; pending = 0;
        end
      end else begin
        pending = 0; mem_busywait = 1'b0;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic reset_dut();
    @(negedge clock);
    reset = 1'b1;
    #1 chk("busywait_in_reset", busywait, 0);
  endtask

  // One fetch: returns whether the first cycle stalled, the block address requested and the word delivered.
  task automatic fetch(input logic [9:0] a, output bit miss, output logic [5:0] maddr,
                       output logic [31:0] word);
    int n = 0;
    int mr = 0;
    maddr = '0;
    @(negedge clock);
    reset = 1'b0;
    address = a;
    #1;
    chk("idle_mem_read_low", mem_read, 0);
    miss = busywait;
    if (miss) begin
      while (busywait && n < 100) begin
        @(negedge clock);
        #1;
        n++;
        if (n == 1) chk("mem_read_next_cycle", mem_read, 1);
        if (mem_read) begin
          mr++;
          if (mr == 1) maddr = mem_address;
          else chk("mem_address_held", mem_address, maddr);
        end
      end
      if (busywait) begin
        total++; bad++;
        $display("FAIL fill_timeout: busywait still %b after %0d cycles, required 0", busywait, n);
      end
      chk("miss_latency", n, mr + 2);
    end
    word = readdata;
  endtask

  typedef struct {
    logic [9:0] addr;
    bit         miss;
    logic [5:0] maddr;
  } vec_t;

  bit          mv [8];
  logic [5:0]  mb [8];

  initial begin
    vec_t        vecs [12];
    bit          m;
    logic [5:0]  ma;
    logic [31:0] w;
    int          c01, c3f, cother;
    bit          order_err;

    vecs[0]  = '{10'h000, 1, 6'h00};
    vecs[1]  = '{10'h004, 0, 6'h00};
    vecs[2]  = '{10'h008, 0, 6'h00};
    vecs[3]  = '{10'h00C, 0, 6'h00};
    vecs[4]  = '{10'h080, 1, 6'h08};
    vecs[5]  = '{10'h084, 0, 6'h00};
    vecs[6]  = '{10'h000, 1, 6'h00};
    vecs[7]  = '{10'h00C, 0, 6'h00};
    vecs[8]  = '{10'h0F0, 1, 6'h0F};
    vecs[9]  = '{10'h3FC, 1, 6'h3F};
    vecs[10] = '{10'h0F3, 1, 6'h0F};
    vecs[11] = '{10'h001, 0, 6'h00};

    // Reset state.
    @(negedge clock);
    #1;
    chk("reset_busywait", busywait, 0);
    chk("reset_mem_read", mem_read, 0);
    chk("reset_mem_address", mem_address, 0);
    chk("reset_hit_count", hit_count, 0);
    chk("reset_miss_count", miss_count, 0);

    // Table-driven fetches: hits within a block, conflicts on index 0 and 7, ignored low bits.
    for (int i = 0; i < 12; i++) begin
      lat = i % 3;
      fetch(vecs[i].addr, m, ma, w);
      chk($sformatf("vec%0d_miss", i), m, vecs[i].miss);
      if (vecs[i].miss) chk($sformatf("vec%0d_mem_address", i), ma, vecs[i].maddr);
      chk($sformatf("vec%0d_readdata", i), w, memword(vecs[i].addr[9:4], vecs[i].addr[3:2]));
    end

    // Address moves to 10'h3F0 while 10'h010 is being filled.
    reset_dut();
    lat = 2;
    @(negedge clock);
    reset = 1'b0;
    address = 10'h010;
    #1 chk("chg_first_miss", busywait, 1);
    c01 = 0; c3f = 0; cother = 0; order_err = 0;
    for (int n = 0; n < 100 && busywait; n++) begin
      @(negedge clock);
      address = 10'h3F0;
      #1;
      if (mem_read) begin
        if (mem_address == 6'h01) begin
          c01++;
          if (c3f > 0) order_err = 1;
        end else if (mem_address == 6'h3F) c3f++;
        else cother++;
      end
    end
    chk("chg_busywait_done", busywait, 0);
    chk("chg_saw_01", c01 > 0, 1);
    chk("chg_saw_3f", c3f > 0, 1);
    chk("chg_other_addr", cother, 0);
    chk("chg_order", order_err, 0);
    chk("chg_readdata", readdata, memword(6'h3F, 2'd0));
    fetch(10'h014, m, ma, w);
    chk("chg_line1_hit", m, 0);
    chk("chg_line1_data", w, memword(6'h01, 2'd1));

    // Reset while the fill for 10'h020 is in MEM_READ.
    lat = 3;
    @(negedge clock);
    address = 10'h020;
    #1 chk("rst_fill_miss", busywait, 1);
    @(negedge clock);
    #1 chk("rst_fill_mem_read", mem_read, 1);
    reset_dut();
    fetch(10'h020, m, ma, w);
    chk("rst_refetch_miss", m, 1);
    chk("rst_refetch_maddr", ma, 6'h02);
    chk("rst_refetch_data", w, memword(6'h02, 2'd0));
    fetch(10'h014, m, ma, w);
    chk("rst_line1_invalid", m, 1);

    // Statistics: 3 misses and 5 hit cycles (each miss replays as one hit).
    reset_dut();
    lat = 1;
    fetch(10'h000, m, ma, w);
    fetch(10'h004, m, ma, w);
    fetch(10'h080, m, ma, w);
    fetch(10'h100, m, ma, w);
    fetch(10'h104, m, ma, w);
    @(negedge clock);
    #1;
`ifdef ICACHE_STATS_EN
    chk("stats_miss_count", miss_count, 3);
    chk("stats_hit_count", hit_count, 5);
`else
    chk("stats_miss_count", miss_count, 0);
    chk("stats_hit_count", hit_count, 0);
`endif
    reset_dut();
    @(negedge clock);
    #1;
    chk("stats_cleared_miss", miss_count, 0);
    chk("stats_cleared_hit", hit_count, 0);

    // Random fetches against a line-level reference model.
    for (int i = 0; i < 8; i++) mv[i] = 0;
    for (int i = 0; i < 300; i++) begin
      logic [2:0] tg, ix;
      logic [3:0] lo;
      logic [9:0] a;
      bit         exp_miss;
      if ($urandom_range(0, 24) == 0) begin
        reset_dut();
        for (int j = 0; j < 8; j++) mv[j] = 0;
      end
      lat = $urandom_range(0, 3);
      tg = 3'($urandom_range(0, 2));
      ix = 3'($urandom_range(0, 7));
      lo = 4'($urandom_range(0, 15));
      a = {tg, ix, lo};
      exp_miss = !(mv[ix] && mb[ix] == a[9:4]);
      fetch(a, m, ma, w);
      chk($sformatf("rnd%0d_miss", i), m, exp_miss);
      if (exp_miss) chk($sformatf("rnd%0d_maddr", i), ma, a[9:4]);
      chk($sformatf("rnd%0d_data", i), w, memword(a[9:4], a[3:2]));
      mv[ix] = 1;
      mb[ix] = a[9:4];
    end
`ifndef ICACHE_STATS_EN
    chk("nostats_hit_zero", hit_count, 0);
    chk("nostats_miss_zero", miss_count, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
